// File: rtl/pmod_adc_block_if.sv
// Control, status and ADC pin bundle for pmod_adc_block; the master modport is the SPI controller side.
interface pmod_adc_block_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  start;
    logic                  continuous;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] dout0;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  frame_err;
    logic                  adc_cs_n;
    logic                  adc_sclk;
    logic                  adc_sdata0;
    logic                  adc_sdata1;

    modport master (
        input  start, continuous, adc_sdata0, adc_sdata1,
        output busy, done, dout0, dout1, frame_err, adc_cs_n, adc_sclk
    );

    modport slave (
        output start, continuous, adc_sdata0, adc_sdata1,
        input  busy, done, dout0, dout1, frame_err, adc_cs_n, adc_sclk
    );
endinterface

// File: rtl/pmod_adc_block.sv
// Dual-channel 16-bit-frame SPI read master for an AD7476A-class PMOD ADC; frame = 33*CLK_DIV clk then QUIET_CYCLES.
// Channel 1 capture only exists when PMOD_ADC_DUAL_CH_EN is defined; otherwise dout1 reads 0.
module pmod_adc_block #(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 4,
    parameter int DATA_WIDTH   = 12
) (
    input  logic              clk,
    input  logic              rst,
    pmod_adc_block_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        QUIET    = 3'd4
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]  QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam logic [15:0] LEAD_MASK  = 16'hFFFF << DATA_WIDTH;

    state_t r_state;
    state_t w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [4:0]  r_bit;
    logic [4:0]  w_bit_nxt;
    logic        w_sample;
    logic        w_frame_done;

    logic        r_cs_n;
    logic        r_sclk;
    logic        r_busy;
    logic        r_done;
    logic        r_frame_err;
    logic [15:0] r_shift0;
    logic [DATA_WIDTH-1:0] r_dout0;
    logic        w_err0;
    logic        w_err1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_bit   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_sample     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start || bus.continuous) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = 8'd0;
                    w_bit_nxt   = 5'd0;
                end
            end
            SETUP: begin
                if (r_cnt == DIV_LAST) begin
                    w_state_nxt = SHIFT_LO;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            SHIFT_LO: begin
                // Data is captured on the edge that raises sclk.
                if (r_cnt == DIV_LAST) begin
                    w_state_nxt = SHIFT_HI;
                    w_cnt_nxt   = 8'd0;
                    w_sample    = 1'b1;
                    w_bit_nxt   = r_bit + 5'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = 8'd0;
                    if (r_bit < 5'd16) begin
                        w_state_nxt = SHIFT_LO;
                    end else begin
                        w_state_nxt  = QUIET;
                        w_frame_done = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            QUIET: begin
                if (r_cnt == QUIET_LAST) begin
                    w_cnt_nxt   = 8'd0;
                    w_bit_nxt   = 5'd0;
                    w_state_nxt = bus.continuous ? SETUP : IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
                w_bit_nxt   = 5'd0;
            end
        endcase
    end

    // Pin and status outputs are registered from the next state so they change glitch-free with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_n <= 1'b1;
            r_sclk <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cs_n <= !((w_state_nxt == SETUP) || (w_state_nxt == SHIFT_LO) ||
                        (w_state_nxt == SHIFT_HI));
            r_sclk <= (w_state_nxt != SHIFT_LO);
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_frame_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift0    <= 16'd0;
            r_dout0     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_sample) begin
                r_shift0 <= {r_shift0[14:0], bus.adc_sdata0};
            end
            if (w_frame_done) begin
                r_dout0     <= r_shift0[DATA_WIDTH-1:0];
                r_frame_err <= w_err0 | w_err1;
            end
        end
    end

    assign w_err0 = |(r_shift0 & LEAD_MASK);

`ifdef PMOD_ADC_DUAL_CH_EN
    logic [15:0]           r_shift1;
    logic [DATA_WIDTH-1:0] r_dout1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift1 <= 16'd0;
            r_dout1  <= '0;
        end else begin
            if (w_sample) begin
                r_shift1 <= {r_shift1[14:0], bus.adc_sdata1};
            end
            if (w_frame_done) begin
                r_dout1 <= r_shift1[DATA_WIDTH-1:0];
            end
        end
    end

    assign w_err1    = |(r_shift1 & LEAD_MASK);
    assign bus.dout1 = r_dout1;
`else
    assign w_err1    = 1'b0;
    assign bus.dout1 = '0;
`endif

    assign bus.adc_cs_n  = r_cs_n;
    assign bus.adc_sclk  = r_sclk;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dout0     = r_dout0;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_pmod_adc_block.sv
// Directed bench for pmod_adc_block with a behavioural dual-SDATA ADC model.
module tb_pmod_adc_block;

`ifdef PMOD_ADC_DUAL_CH_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pmod_adc_block_if #(.DATA_WIDTH(12)) bus ();

    pmod_adc_block #(
        .CLK_DIV(4),
        .QUIET_CYCLES(4),
        .DATA_WIDTH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: bit 15 appears when cs_n falls, next bit after each sclk rise.
    logic [15:0] f0;
    logic [15:0] f1;
    int          idx;
    initial idx = 16;
    always @(negedge bus.adc_cs_n) idx = 0;
    always @(posedge bus.adc_sclk) if (bus.adc_cs_n === 1'b0) idx = idx + 1;
    assign bus.adc_sdata0 = (idx < 16) ? f0[15 - idx] : 1'b0;
    assign bus.adc_sdata1 = (idx < 16) ? f1[15 - idx] : 1'b0;

    int     rise_cnt;
    int     idle_toggles;
    longint last_rise;
    longint per_min;
    longint per_max;
    always @(negedge bus.adc_cs_n) last_rise = -1;
    always @(posedge bus.adc_sclk) begin
        if (bus.adc_cs_n === 1'b0) begin
            rise_cnt = rise_cnt + 1;
            if (last_rise >= 0) begin
                if ($time - last_rise < per_min) per_min = $time - last_rise;
                if ($time - last_rise > per_max) per_max = $time - last_rise;
            end
            last_rise = $time;
        end
    end
    always @(bus.adc_sclk) if (bus.adc_cs_n === 1'b1) idle_toggles = idle_toggles + 1;

    function automatic logic [11:0] exp1(input logic [15:0] f);
        return DUAL ? f[11:0] : 12'h000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves start high during cycle 0; it is sampled on edge 1.
    task automatic pulse_start();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.continuous = 1'b0;
        f0 = 16'h0;
        f1 = 16'h0;
        tick(2);
        total += 7;
        if (bus.adc_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got %b want 1", bus.adc_cs_n); end
        if (bus.adc_sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got %b want 1", bus.adc_sclk); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.dout0 !== 12'h0) begin bad++; $display("FAIL reset_dout0 got %h want 000", bus.dout0); end
        if (bus.dout1 !== 12'h0) begin bad++; $display("FAIL reset_dout1 got %h want 000", bus.dout1); end
        if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
        @(negedge clk);
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_single();
        f0 = 16'h0ABC;
        f1 = 16'h0123;
        rise_cnt = 0;
        idle_toggles = 0;
        per_min = 64'd1000000;
        per_max = 0;
        pulse_start();
        total += 2;
        if (bus.adc_cs_n !== 1'b1) begin bad++; $display("FAIL single_cs_c0 got %b want 1", bus.adc_cs_n); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_c0 got %b want 0", bus.busy); end
        tick(1);
        bus.start = 1'b0;
        total += 2;
        if (bus.adc_cs_n !== 1'b0) begin bad++; $display("FAIL single_cs_c1 got %b want 0", bus.adc_cs_n); end
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_c1 got %b want 1", bus.busy); end
        tick(131);
        total += 1;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_c132 got %b want 0", bus.done); end
        tick(1);
        total += 5;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL single_done_c133 got %b want 1", bus.done); end
        if (bus.dout0 !== 12'hABC) begin bad++; $display("FAIL single_dout0 got %h want abc", bus.dout0); end
        if (bus.dout1 !== exp1(f1)) begin bad++; $display("FAIL single_dout1 got %h want %h", bus.dout1, exp1(f1)); end
        if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL single_frame_err got %b want 0", bus.frame_err); end
        if (bus.adc_cs_n !== 1'b1) begin bad++; $display("FAIL single_cs_c133 got %b want 1", bus.adc_cs_n); end
        tick(1);
        total += 1;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_c134 got %b want 0", bus.done); end
        tick(2);
        total += 1;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_c136 got %b want 1", bus.busy); end
        tick(1);
        total += 5;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_c137 got %b want 0", bus.busy); end
        if (rise_cnt !== 16) begin bad++; $display("FAIL sclk_rises got %0d want 16", rise_cnt); end
        if (per_min !== 80) begin bad++; $display("FAIL sclk_period_min got %0d want 80", per_min); end
        if (per_max !== 80) begin bad++; $display("FAIL sclk_period_max got %0d want 80", per_max); end
        if (idle_toggles !== 0) begin bad++; $display("FAIL sclk_idle_toggles got %0d want 0", idle_toggles); end
        tick(5);
    endtask

    task automatic test_start_ignored();
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc = -1;
        f0 = 16'h0321;
        f1 = 16'h0654;
        pulse_start();
        for (int c = 1; c <= 145; c++) begin
            if (c == 51) bus.start = 1'b1;
            tick(1);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                dcyc = c;
            end
        end
        total += 4;
        if (ndone !== 1) begin bad++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
        if (dcyc !== 133) begin bad++; $display("FAIL ignored_done_cycle got %0d want 133", dcyc); end
        if (bus.dout0 !== 12'h321) begin bad++; $display("FAIL ignored_dout0 got %h want 321", bus.dout0); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignored_busy_end got %b want 0", bus.busy); end
        tick(3);
    endtask

    task automatic test_frame_err();
        f0 = 16'h8FFF;
        f1 = 16'h0000;
        pulse_start();
        tick(1);
        bus.start = 1'b0;
        tick(132);
        total += 4;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL err_done got %b want 1", bus.done); end
        if (bus.dout0 !== 12'hFFF) begin bad++; $display("FAIL err_dout0 got %h want fff", bus.dout0); end
        if (bus.dout1 !== 12'h000) begin bad++; $display("FAIL err_dout1 got %h want 000", bus.dout1); end
        if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL err_flag got %b want 1", bus.frame_err); end
        tick(30);
        total += 1;
        if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL err_flag_hold got %b want 1", bus.frame_err); end
        f0 = 16'h0555;
        f1 = 16'h0AAA;
        pulse_start();
        tick(1);
        bus.start = 1'b0;
        tick(132);
        total += 4;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL clean_done got %b want 1", bus.done); end
        if (bus.dout0 !== 12'h555) begin bad++; $display("FAIL clean_dout0 got %h want 555", bus.dout0); end
        if (bus.dout1 !== exp1(f1)) begin bad++; $display("FAIL clean_dout1 got %h want %h", bus.dout1, exp1(f1)); end
        if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL clean_flag got %b want 0", bus.frame_err); end
        tick(10);
    endtask

    task automatic test_continuous();
        logic [15:0] seq0 [3];
        logic [15:0] seq1 [3];
        int cyc;
        int prev;
        int w;
        seq0[0] = 16'h0111; seq0[1] = 16'h0222; seq0[2] = 16'h0333;
        seq1[0] = 16'h0EEE; seq1[1] = 16'h0DDD; seq1[2] = 16'h0CCC;
        f0 = seq0[0];
        f1 = seq1[0];
        cyc = 0;
        prev = 0;
        @(posedge clk);
        #1;
        bus.continuous = 1'b1;
        for (int n = 0; n < 3; n++) begin
            w = 0;
            do begin
                tick(1);
                cyc++;
                w++;
            end while (bus.done !== 1'b1 && w < 300);
            total += 3;
            if (bus.done !== 1'b1) begin
                bad++;
                $display("FAIL cont_done_timeout frame %0d got no done want done", n);
            end
            if (cyc - prev !== ((n == 0) ? 133 : 136)) begin
                bad++;
                $display("FAIL cont_interval frame %0d got %0d want %0d", n, cyc - prev, (n == 0) ? 133 : 136);
            end
            if (bus.dout0 !== seq0[n][11:0]) begin
                bad++;
                $display("FAIL cont_dout0 frame %0d got %h want %h", n, bus.dout0, seq0[n][11:0]);
            end
            prev = cyc;
            if (n < 2) begin
                f0 = seq0[n + 1];
                f1 = seq1[n + 1];
            end
            if (n == 1) begin
                tick(60);
                cyc += 60;
                bus.continuous = 1'b0;
            end
        end
        tick(3);
        total += 1;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL cont_busy_quiet got %b want 1", bus.busy); end
        tick(1);
        total += 1;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL cont_busy_end got %b want 0", bus.busy); end
        tick(20);
        total += 2;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL cont_stays_idle got %b want 0", bus.busy); end
        if (bus.adc_cs_n !== 1'b1) begin bad++; $display("FAIL cont_cs_idle got %b want 1", bus.adc_cs_n); end
    endtask

    task automatic test_reset_mid();
        f0 = 16'h0ABC;
        f1 = 16'h0123;
        pulse_start();
        tick(1);
        bus.start = 1'b0;
        tick(59);
        total += 1;
        if (bus.adc_cs_n !== 1'b0) begin bad++; $display("FAIL rstmid_pre_cs got %b want 0", bus.adc_cs_n); end
        rst = 1'b1;
        #1;
        total += 5;
        if (bus.adc_cs_n !== 1'b1) begin bad++; $display("FAIL rstmid_cs got %b want 1", bus.adc_cs_n); end
        if (bus.adc_sclk !== 1'b1) begin bad++; $display("FAIL rstmid_sclk got %b want 1", bus.adc_sclk); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        if (bus.dout0 !== 12'h000) begin bad++; $display("FAIL rstmid_dout0 got %h want 000", bus.dout0); end
        if (bus.dout1 !== 12'h000) begin bad++; $display("FAIL rstmid_dout1 got %h want 000", bus.dout1); end
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        f0 = 16'h0456;
        f1 = 16'h0789;
        pulse_start();
        tick(1);
        bus.start = 1'b0;
        tick(132);
        total += 4;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL after_rst_done got %b want 1", bus.done); end
        if (bus.dout0 !== 12'h456) begin bad++; $display("FAIL after_rst_dout0 got %h want 456", bus.dout0); end
        if (bus.dout1 !== exp1(f1)) begin bad++; $display("FAIL after_rst_dout1 got %h want %h", bus.dout1, exp1(f1)); end
        if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL after_rst_flag got %b want 0", bus.frame_err); end
        tick(6);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rise_cnt = 0;
        idle_toggles = 0;
        last_rise = -1;
        per_min = 64'd1000000;
        per_max = 0;
        test_reset();
        test_single();
        test_start_ignored();
        test_frame_err();
        test_continuous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
